// File: rtl/fetch_pkg.sv
// Shared types and default widths for the instruction fetch sequencer.
package fetch_pkg;

    typedef enum logic [1:0] {IDLE, REQUEST, HOLD} fetch_state_t;

    localparam int OPERAND_WIDTH_DEF = 11;
    localparam int INSTR_WIDTH_DEF   = 16;

endpackage

// File: rtl/instruction_fetch_if.sv
// Bundle of PC, memory-read, instruction-register and branch signals around the fetch unit.
// Handshakes: memory read completes in the cycle mem_rd_req && mem_rd_ack (data valid that cycle);
// the decoder takes ir_out in the cycle ir_valid && ir_ready; ir_out/ir_valid hold otherwise.
interface instruction_fetch_if import fetch_pkg::*; #(
    parameter int OPERAND_WIDTH = OPERAND_WIDTH_DEF,
    parameter int INSTR_WIDTH   = INSTR_WIDTH_DEF
) ();

    logic                     fetch_en;
    logic [OPERAND_WIDTH-1:0] pc_value;
    logic [OPERAND_WIDTH-1:0] pc_next;
    logic                     pc_wr;
    logic [OPERAND_WIDTH-1:0] mem_addr;
    logic                     mem_rd_req;
    logic                     mem_rd_ack;
    logic [INSTR_WIDTH-1:0]   mem_rd_data;
    logic [INSTR_WIDTH-1:0]   ir_out;
    logic                     ir_valid;
    logic                     ir_ready;
    logic                     branch_en;
    logic [OPERAND_WIDTH-1:0] branch_target;

    modport master (
        input  fetch_en, pc_value, mem_rd_ack, mem_rd_data, ir_ready, branch_en, branch_target,
        output pc_next, pc_wr, mem_addr, mem_rd_req, ir_out, ir_valid
    );

    modport slave (
        output fetch_en, pc_value, mem_rd_ack, mem_rd_data, ir_ready, branch_en, branch_target,
        input  pc_next, pc_wr, mem_addr, mem_rd_req, ir_out, ir_valid
    );

endinterface

// File: rtl/instruction_fetch.sv
// Fetch sequencer: reads one instruction per PC, presents it through a valid/ready IR,
// and is the sole writer of the program counter (sequential advance and branch redirects).
module instruction_fetch import fetch_pkg::*; #(
    parameter int OPERAND_WIDTH = OPERAND_WIDTH_DEF,
    parameter int INSTR_WIDTH   = INSTR_WIDTH_DEF
) (
    input  logic                clock,
    input  logic                fetch_reset_n,
    instruction_fetch_if.master bus,
    output fetch_state_t        state_dbg
);

    fetch_state_t             state_q, state_d;
    logic [INSTR_WIDTH-1:0]   ir_out_q, ir_out_d;
    logic                     ir_valid_q, ir_valid_d;
    logic                     redirect_pend_q, redirect_pend_d;
    logic [OPERAND_WIDTH-1:0] redirect_pc_q, redirect_pc_d;
    logic                     pc_wr;
    logic [OPERAND_WIDTH-1:0] pc_next;

    always_ff @(posedge clock or negedge fetch_reset_n) begin
        if (!fetch_reset_n) begin
            state_q         <= IDLE;
            ir_out_q        <= '0;
            ir_valid_q      <= 1'b0;
            redirect_pend_q <= 1'b0;
            redirect_pc_q   <= '0;
        end else begin
            state_q         <= state_d;
            ir_out_q        <= ir_out_d;
            ir_valid_q      <= ir_valid_d;
            redirect_pend_q <= redirect_pend_d;
            redirect_pc_q   <= redirect_pc_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        ir_out_d        = ir_out_q;
        ir_valid_d      = ir_valid_q;
        redirect_pend_d = redirect_pend_q;
        redirect_pc_d   = redirect_pc_q;
        pc_wr           = 1'b0;
        pc_next         = bus.pc_value;

        unique case (state_q)
            IDLE: begin
                if (bus.branch_en) begin
                    pc_wr   = 1'b1;
                    pc_next = bus.branch_target;
                end
                if (bus.fetch_en) state_d = REQUEST;
            end

            REQUEST: begin
                if (bus.mem_rd_ack) begin
                    if (redirect_pend_q || bus.branch_en) begin
                        // Stale fetch: drop the data and jump to the newest target.
                        pc_wr           = 1'b1;
                        pc_next         = bus.branch_en ? bus.branch_target : redirect_pc_q;
                        redirect_pend_d = 1'b0;
                        state_d         = bus.fetch_en ? REQUEST : IDLE;
                    end else begin
                        ir_out_d   = bus.mem_rd_data;
                        ir_valid_d = 1'b1;
                        pc_wr      = 1'b1;
                        pc_next    = bus.pc_value + OPERAND_WIDTH'(1);
                        state_d    = HOLD;
                    end
                end else if (bus.branch_en) begin
                    // PC stays put so mem_addr is stable until the ack arrives.
                    redirect_pend_d = 1'b1;
                    redirect_pc_d   = bus.branch_target;
                end
            end

            HOLD: begin
                if (bus.branch_en) begin
                    ir_valid_d = 1'b0;
                    pc_wr      = 1'b1;
                    pc_next    = bus.branch_target;
                    state_d    = bus.fetch_en ? REQUEST : IDLE;
                end else if (bus.ir_ready) begin
                    ir_valid_d = 1'b0;
                    state_d    = bus.fetch_en ? REQUEST : IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    assign bus.pc_wr      = pc_wr;
    assign bus.pc_next    = pc_next;
    assign bus.mem_addr   = bus.pc_value;
    assign bus.mem_rd_req = (state_q == REQUEST);
    assign bus.ir_out     = ir_out_q;
    assign bus.ir_valid   = ir_valid_q;
    assign state_dbg      = state_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios plus a randomized sequential fetch stream
// checked against an address/data scoreboard; the program counter is modelled beside the DUT.
module tb_instruction_fetch;
    import fetch_pkg::*;

    localparam int OW = 11;
    localparam int IW = 16;

    logic          clock = 1'b0;
    logic          fetch_reset_n = 1'b0;
    fetch_state_t  state_dbg;
    logic [OW-1:0] pc_q;
    logic [IW-1:0] mem [0:2047];
    logic [IW-1:0] exp_q[$];
    int            tests_run = 0;
    int            tests_failed = 0;

    instruction_fetch_if #(.OPERAND_WIDTH(OW), .INSTR_WIDTH(IW)) bus ();

    instruction_fetch #(.OPERAND_WIDTH(OW), .INSTR_WIDTH(IW)) dut (
        .clock         (clock),
        .fetch_reset_n (fetch_reset_n),
        .bus           (bus),
        .state_dbg     (state_dbg)
    );

    // clock / reset and program counter beside the DUT
    always #5 clock = ~clock;

    always @(posedge clock or negedge fetch_reset_n) begin
        if (!fetch_reset_n) pc_q <= '0;
        else if (bus.pc_wr) pc_q <= bus.pc_next;
    end
    assign bus.pc_value = pc_q;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, tests_run=%0d", tests_run);
        $fatal(1, "watchdog");
    end

    // driver tasks
    task automatic step();
        @(negedge clock);
    endtask

    task automatic set_pc(input logic [OW-1:0] v);
        step();
        bus.branch_en = 1'b1;
        bus.branch_target = v;
        step();
        bus.branch_en = 1'b0;
    endtask

    task automatic go_idle();
        bus.fetch_en = 1'b0;
        bus.branch_en = 1'b0;
        for (int i = 0; i < 20 && state_dbg != IDLE; i++) begin
            bus.mem_rd_ack = (state_dbg == REQUEST);
            bus.mem_rd_data = '0;
            bus.ir_ready = 1'b1;
            step();
        end
        bus.mem_rd_ack = 1'b0;
        bus.ir_ready = 1'b0;
        tests_run++; if (state_dbg !== IDLE) begin tests_failed++; $display("FAIL go_idle: state %0d, required IDLE", state_dbg); end
    endtask

    // scenarios
    task automatic test_reset();
        #1;
        tests_run++; if (bus.mem_rd_req !== 1'b0) begin tests_failed++; $display("FAIL rst_req: got %b want 0", bus.mem_rd_req); end
        tests_run++; if (bus.ir_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_valid: got %b want 0", bus.ir_valid); end
        tests_run++; if (bus.ir_out !== 16'h0) begin tests_failed++; $display("FAIL rst_ir: got %h want 0000", bus.ir_out); end
        tests_run++; if (bus.pc_wr !== 1'b0) begin tests_failed++; $display("FAIL rst_pcwr: got %b want 0", bus.pc_wr); end
        step(); step();
        fetch_reset_n = 1'b1;
        step(); #1;
        tests_run++; if (state_dbg !== IDLE) begin tests_failed++; $display("FAIL rst_idle: got %0d want IDLE", state_dbg); end
        tests_run++; if (bus.mem_rd_req !== 1'b0) begin tests_failed++; $display("FAIL rst_idle_req: got %b want 0", bus.mem_rd_req); end
    endtask

    task automatic test_wait_fetch();
        int pulses = 0;
        set_pc(11'h005);
        bus.fetch_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            bus.mem_rd_ack = (i == 3);
            bus.mem_rd_data = 16'hA1B2;
            #1;
            pulses += int'(bus.pc_wr);
            tests_run++; if (bus.mem_rd_req !== 1'b1) begin tests_failed++; $display("FAIL wait_req[%0d]: got %b want 1", i, bus.mem_rd_req); end
            tests_run++; if (bus.mem_addr !== 11'h005) begin tests_failed++; $display("FAIL wait_addr[%0d]: got %h want 005", i, bus.mem_addr); end
            if (i == 3) begin
                tests_run++; if (bus.pc_next !== 11'h006) begin tests_failed++; $display("FAIL wait_pcnext: got %h want 006", bus.pc_next); end
            end
        end
        tests_run++; if (pulses != 1) begin tests_failed++; $display("FAIL wait_pulses: got %0d want 1", pulses); end
        step();
        bus.mem_rd_ack = 1'b0;
        #1;
        tests_run++; if (bus.ir_valid !== 1'b1) begin tests_failed++; $display("FAIL wait_valid: got %b want 1", bus.ir_valid); end
        tests_run++; if (bus.ir_out !== 16'hA1B2) begin tests_failed++; $display("FAIL wait_ir: got %h want a1b2", bus.ir_out); end
        tests_run++; if (pc_q !== 11'h006) begin tests_failed++; $display("FAIL wait_pc: got %h want 006", pc_q); end
        tests_run++; if (bus.mem_rd_req !== 1'b0) begin tests_failed++; $display("FAIL wait_hold_req: got %b want 0", bus.mem_rd_req); end
    endtask

    task automatic test_hold_stall();
        logic [IW-1:0] d;
        bus.ir_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(); #1;
            tests_run++; if (bus.ir_valid !== 1'b1 || bus.ir_out !== 16'hA1B2) begin tests_failed++; $display("FAIL stall_hold[%0d]: got v=%b ir=%h want v=1 ir=a1b2", i, bus.ir_valid, bus.ir_out); end
            tests_run++; if (bus.mem_rd_req !== 1'b0) begin tests_failed++; $display("FAIL stall_req[%0d]: got %b want 0", i, bus.mem_rd_req); end
        end
        bus.ir_ready = 1'b1;
        step();
        bus.ir_ready = 1'b0;
        #1;
        tests_run++; if (bus.mem_rd_req !== 1'b1 || bus.mem_addr !== 11'h006) begin tests_failed++; $display("FAIL stall_next: got req=%b addr=%h want req=1 addr=006", bus.mem_rd_req, bus.mem_addr); end
        tests_run++; if (bus.ir_valid !== 1'b0) begin tests_failed++; $display("FAIL stall_consumed: got %b want 0", bus.ir_valid); end
        d = IW'($urandom);
        bus.mem_rd_ack = 1'b1;
        bus.mem_rd_data = d;
        #1;
        tests_run++; if (bus.pc_wr !== 1'b1 || bus.pc_next !== 11'h007) begin tests_failed++; $display("FAIL stall_pcnext: got wr=%b next=%h want wr=1 next=007", bus.pc_wr, bus.pc_next); end
        step();
        bus.mem_rd_ack = 1'b0;
        #1;
        tests_run++; if (bus.ir_out !== d) begin tests_failed++; $display("FAIL stall_ir: got %h want %h", bus.ir_out, d); end
    endtask

    task automatic test_wrap();
        logic [IW-1:0] d;
        go_idle();
        set_pc(11'h7FF);
        bus.fetch_en = 1'b1;
        step();
        d = IW'($urandom);
        bus.mem_rd_ack = 1'b1;
        bus.mem_rd_data = d;
        #1;
        tests_run++; if (bus.mem_addr !== 11'h7FF) begin tests_failed++; $display("FAIL wrap_addr: got %h want 7ff", bus.mem_addr); end
        tests_run++; if (bus.pc_wr !== 1'b1 || bus.pc_next !== 11'h000) begin tests_failed++; $display("FAIL wrap_pcnext: got wr=%b next=%h want wr=1 next=000", bus.pc_wr, bus.pc_next); end
        step();
        bus.mem_rd_ack = 1'b0;
        bus.fetch_en = 1'b0;
        #1;
        tests_run++; if (bus.ir_out !== d || bus.ir_valid !== 1'b1) begin tests_failed++; $display("FAIL wrap_ir: got v=%b ir=%h want v=1 ir=%h", bus.ir_valid, bus.ir_out, d); end
        tests_run++; if (pc_q !== 11'h000) begin tests_failed++; $display("FAIL wrap_pc: got %h want 000", pc_q); end
    endtask

    task automatic test_redirect_in_request();
        logic [IW-1:0] d;
        go_idle();
        set_pc(11'h200);
        bus.fetch_en = 1'b1;
        step();
        bus.branch_en = 1'b1;
        bus.branch_target = 11'h040;
        #1;
        tests_run++; if (bus.pc_wr !== 1'b0 || bus.mem_rd_req !== 1'b1) begin tests_failed++; $display("FAIL redir_br1: got wr=%b req=%b want wr=0 req=1", bus.pc_wr, bus.mem_rd_req); end
        step();
        bus.branch_target = 11'h080;
        #1;
        tests_run++; if (bus.pc_wr !== 1'b0 || bus.mem_addr !== 11'h200) begin tests_failed++; $display("FAIL redir_br2: got wr=%b addr=%h want wr=0 addr=200", bus.pc_wr, bus.mem_addr); end
        step();
        bus.branch_en = 1'b0;
        bus.mem_rd_ack = 1'b1;
        bus.mem_rd_data = 16'h1234;
        #1;
        tests_run++; if (bus.pc_wr !== 1'b1 || bus.pc_next !== 11'h080) begin tests_failed++; $display("FAIL redir_pcnext: got wr=%b next=%h want wr=1 next=080", bus.pc_wr, bus.pc_next); end
        step();
        bus.mem_rd_ack = 1'b0;
        #1;
        tests_run++; if (bus.ir_valid !== 1'b0) begin tests_failed++; $display("FAIL redir_discard: got %b want 0", bus.ir_valid); end
        tests_run++; if (bus.mem_rd_req !== 1'b1 || bus.mem_addr !== 11'h080) begin tests_failed++; $display("FAIL redir_refetch: got req=%b addr=%h want req=1 addr=080", bus.mem_rd_req, bus.mem_addr); end
        d = IW'($urandom);
        bus.mem_rd_ack = 1'b1;
        bus.mem_rd_data = d;
        #1;
        tests_run++; if (bus.pc_next !== 11'h081) begin tests_failed++; $display("FAIL redir_seq: got %h want 081", bus.pc_next); end
        step();
        bus.mem_rd_ack = 1'b0;
        #1;
        tests_run++; if (bus.ir_valid !== 1'b1 || bus.ir_out !== d) begin tests_failed++; $display("FAIL redir_ir: got v=%b ir=%h want v=1 ir=%h", bus.ir_valid, bus.ir_out, d); end
    endtask

    task automatic test_hold_branch();
        bus.branch_en = 1'b1;
        bus.branch_target = 11'h010;
        bus.ir_ready = 1'b1;
        #1;
        tests_run++; if (bus.pc_wr !== 1'b1 || bus.pc_next !== 11'h010) begin tests_failed++; $display("FAIL hbr_pcnext: got wr=%b next=%h want wr=1 next=010", bus.pc_wr, bus.pc_next); end
        step();
        bus.branch_en = 1'b0;
        bus.ir_ready = 1'b0;
        #1;
        tests_run++; if (bus.ir_valid !== 1'b0) begin tests_failed++; $display("FAIL hbr_flush: got %b want 0", bus.ir_valid); end
        tests_run++; if (bus.mem_rd_req !== 1'b1 || bus.mem_addr !== 11'h010) begin tests_failed++; $display("FAIL hbr_req: got req=%b addr=%h want req=1 addr=010", bus.mem_rd_req, bus.mem_addr); end
        bus.branch_en = 1'b1;
        bus.branch_target = 11'h020;
        #1;
        tests_run++; if (bus.pc_wr !== 1'b0) begin tests_failed++; $display("FAIL coinc_pend: got %b want 0", bus.pc_wr); end
        step();
        bus.branch_target = 11'h030;
        bus.mem_rd_ack = 1'b1;
        bus.mem_rd_data = 16'h1111;
        #1;
        tests_run++; if (bus.pc_wr !== 1'b1 || bus.pc_next !== 11'h030) begin tests_failed++; $display("FAIL coinc_pcnext: got wr=%b next=%h want wr=1 next=030", bus.pc_wr, bus.pc_next); end
        step();
        bus.branch_en = 1'b0;
        bus.mem_rd_ack = 1'b0;
        #1;
        tests_run++; if (bus.ir_valid !== 1'b0 || bus.mem_addr !== 11'h030) begin tests_failed++; $display("FAIL coinc_next: got v=%b addr=%h want v=0 addr=030", bus.ir_valid, bus.mem_addr); end
        bus.mem_rd_ack = 1'b1;
        bus.mem_rd_data = 16'h2222;
        step();
        bus.mem_rd_ack = 1'b0;
        bus.fetch_en = 1'b0;
        bus.branch_en = 1'b1;
        bus.branch_target = 11'h300;
        #1;
        tests_run++; if (bus.pc_wr !== 1'b1 || bus.pc_next !== 11'h300) begin tests_failed++; $display("FAIL hbr_noready: got wr=%b next=%h want wr=1 next=300", bus.pc_wr, bus.pc_next); end
        step();
        bus.branch_en = 1'b0;
        #1;
        tests_run++; if (state_dbg !== IDLE || bus.ir_valid !== 1'b0) begin tests_failed++; $display("FAIL hbr_idle: got st=%0d v=%b want IDLE v=0", state_dbg, bus.ir_valid); end
        tests_run++; if (pc_q !== 11'h300) begin tests_failed++; $display("FAIL hbr_pc: got %h want 300", pc_q); end
        // redirect completing with fetch_en low: request is finished, then IDLE
        bus.fetch_en = 1'b1;
        step();
        bus.fetch_en = 1'b0;
        bus.branch_en = 1'b1;
        bus.branch_target = 11'h155;
        step();
        bus.branch_en = 1'b0;
        bus.mem_rd_ack = 1'b1;
        #1;
        tests_run++; if (bus.mem_rd_req !== 1'b1 || bus.mem_addr !== 11'h300) begin tests_failed++; $display("FAIL noabort_req: got req=%b addr=%h want req=1 addr=300", bus.mem_rd_req, bus.mem_addr); end
        tests_run++; if (bus.pc_wr !== 1'b1 || bus.pc_next !== 11'h155) begin tests_failed++; $display("FAIL noabort_pcnext: got wr=%b next=%h want wr=1 next=155", bus.pc_wr, bus.pc_next); end
        step();
        bus.mem_rd_ack = 1'b0;
        #1;
        tests_run++; if (state_dbg !== IDLE || bus.ir_valid !== 1'b0) begin tests_failed++; $display("FAIL noabort_idle: got st=%0d v=%b want IDLE v=0", state_dbg, bus.ir_valid); end
    endtask

    task automatic test_idle_branch_fetch();
        bus.branch_en = 1'b1;
        bus.branch_target = 11'h123;
        bus.fetch_en = 1'b1;
        #1;
        tests_run++; if (bus.pc_wr !== 1'b1 || bus.pc_next !== 11'h123 || bus.mem_rd_req !== 1'b0) begin tests_failed++; $display("FAIL ibr_pcnext: got wr=%b next=%h req=%b want 1/123/0", bus.pc_wr, bus.pc_next, bus.mem_rd_req); end
        step();
        bus.branch_en = 1'b0;
        #1;
        tests_run++; if (bus.mem_rd_req !== 1'b1 || bus.mem_addr !== 11'h123) begin tests_failed++; $display("FAIL ibr_req: got req=%b addr=%h want req=1 addr=123", bus.mem_rd_req, bus.mem_addr); end
    endtask

    task automatic test_reset_mid_request();
        bus.mem_rd_ack = 1'b1;
        bus.mem_rd_data = 16'hBEEF;
        step();
        bus.mem_rd_ack = 1'b0;
        bus.ir_ready = 1'b1;
        step();
        bus.ir_ready = 1'b0;
        #1;
        tests_run++; if (bus.mem_rd_req !== 1'b1 || bus.ir_out !== 16'hBEEF || bus.ir_valid !== 1'b0) begin tests_failed++; $display("FAIL mid_pre: got req=%b ir=%h v=%b want 1/beef/0", bus.mem_rd_req, bus.ir_out, bus.ir_valid); end
        fetch_reset_n = 1'b0;
        #1;
        tests_run++; if (bus.mem_rd_req !== 1'b0) begin tests_failed++; $display("FAIL mid_req: got %b want 0", bus.mem_rd_req); end
        tests_run++; if (bus.ir_out !== 16'h0 || bus.ir_valid !== 1'b0) begin tests_failed++; $display("FAIL mid_ir: got v=%b ir=%h want v=0 ir=0000", bus.ir_valid, bus.ir_out); end
        tests_run++; if (state_dbg !== IDLE) begin tests_failed++; $display("FAIL mid_state: got %0d want IDLE", state_dbg); end
        step(); step();
        bus.fetch_en = 1'b0;
        fetch_reset_n = 1'b1;
        step(); #1;
        tests_run++; if (state_dbg !== IDLE || bus.mem_rd_req !== 1'b0) begin tests_failed++; $display("FAIL mid_release: got st=%0d req=%b want IDLE req=0", state_dbg, bus.mem_rd_req); end
    endtask

    // Random wait states, decoder stalls and fetch_en drops: the decoder must still see
    // mem[start], mem[start+1], ... in order (wrapping at 2^11), one fetch per address.
    task automatic test_random_stream();
        int            accepted = 0;
        int            wait_left = 0;
        bit            in_req = 1'b0;
        logic [OW-1:0] exp_addr;
        logic [IW-1:0] exp_d;
        go_idle();
        exp_addr = OW'($urandom_range(2000, 2047));
        set_pc(exp_addr);
        exp_q.delete();
        for (int cyc = 0; cyc < 3000 && accepted < 40; cyc++) begin
            bus.fetch_en = ($urandom_range(0, 3) != 0);
            bus.ir_ready = 1'($urandom_range(0, 1));
            bus.mem_rd_ack = 1'b0;
            if (bus.mem_rd_req) begin
                if (!in_req) begin
                    in_req = 1'b1;
                    wait_left = $urandom_range(0, 3);
                end
                if (wait_left == 0) begin
                    tests_run++; if (bus.mem_addr !== exp_addr) begin tests_failed++; $display("FAIL rnd_addr: got %h want %h", bus.mem_addr, exp_addr); end
                    bus.mem_rd_ack = 1'b1;
                    bus.mem_rd_data = mem[exp_addr];
                    exp_q.push_back(mem[exp_addr]);
                    exp_addr = exp_addr + 1'b1;
                    in_req = 1'b0;
                end else begin
                    wait_left--;
                end
            end
            #1;
            if (bus.ir_valid && bus.ir_ready) begin
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++; $display("FAIL rnd_extra: got ir=%h with no fetch outstanding", bus.ir_out);
                end else begin
                    exp_d = exp_q.pop_front();
                    if (bus.ir_out !== exp_d) begin tests_failed++; $display("FAIL rnd_ir: got %h want %h", bus.ir_out, exp_d); end
                end
                accepted++;
            end
            step();
        end
        bus.mem_rd_ack = 1'b0;
        bus.ir_ready = 1'b0;
        tests_run++; if (accepted != 40) begin tests_failed++; $display("FAIL rnd_timeout: got %0d accepted want 40", accepted); end
    endtask

    initial begin
        bus.fetch_en      = 1'b0;
        bus.mem_rd_ack    = 1'b0;
        bus.mem_rd_data   = '0;
        bus.ir_ready      = 1'b0;
        bus.branch_en     = 1'b0;
        bus.branch_target = '0;
        for (int i = 0; i < 2048; i++) mem[i] = IW'($urandom);

        test_reset();
        test_wait_fetch();
        test_hold_stall();
        test_wrap();
        test_redirect_in_request();
        test_hold_branch();
        test_idle_branch_fetch();
        test_reset_mid_request();
        test_random_stream();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
